// File: rtl/ex_muldiv_hilo.sv
// ex_muldiv_hilo: iterative 32-cycle MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU retire at once and leave HI/LO alone.
module ex_muldiv_hilo #(
  parameter int ITER_CYCLES = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              hi_wen,
  input  logic              lo_wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int               CNT_W    = $clog2(ITER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic is_signed);
    return (is_signed && (v < 0)) ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_signed, s1_neg, s2_neg;
  logic [DATA_W-1:0]   abs1, abs2;
  logic                accept, accept_run, accept_nodiv, last, done_d;
  logic [DATA_W-1:0]   opnd_p0;
  logic                neg_res_p0;
  logic [2*DATA_W-1:0] acc_p1, acc_nx;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_nx, mul_res;
  logic [DATA_W-1:0]   res_hi, res_lo;

  assign is_signed = ~op[0];
  assign s1_neg    = is_signed & src1[DATA_W-1];
  assign s2_neg    = is_signed & src2[DATA_W-1];
  assign abs1      = abs_val(src1, is_signed);
  assign abs2      = abs_val(src2, is_signed);
  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign last      = (state_q == S_RUN) && (cnt_q == CNT_LAST);

`ifdef MULDIV_DIV_EN
  assign accept_run   = accept;
  assign accept_nodiv = 1'b0;
`else
  assign accept_run   = accept && !op[1];
  assign accept_nodiv = accept && op[1];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (accept_run) state_d = S_RUN;
    end else begin
      if (flush || last) state_d = S_IDLE;
    end
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    done_d = (last && !flush) || accept_nodiv;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= done_d;
      if (accept_run)                       cnt_q <= '0;
      else if ((state_q == S_RUN) && !flush) cnt_q <= cnt_q + 1'b1;
    end
  end

  // p0: operand capture; multiplier or dividend rides in the low half of the accumulator
  always_ff @(posedge clk) begin
    if (accept_run) begin
      neg_res_p0 <= s1_neg ^ s2_neg;
      opnd_p0    <= op[1] ? abs2 : abs1;
      acc_p1     <= {{DATA_W{1'b0}}, (op[1] ? abs1 : abs2)};
    end else if (state_q == S_RUN) begin
      acc_p1 <= acc_nx;
    end
  end

  // p1: one shift-add multiply step per cycle
  assign mul_sum = {1'b0, acc_p1[2*DATA_W-1:DATA_W]} + (acc_p1[0] ? {1'b0, opnd_p0} : {(DATA_W+1){1'b0}});
  assign mul_nx  = {mul_sum, acc_p1[DATA_W-1:1]};
  assign mul_res = cond_neg64(mul_nx, neg_res_p0);

`ifdef MULDIV_DIV_EN
  logic              is_div_p0, neg_rem_p0, div0_p0;
  logic [DATA_W-1:0] src1_p0, rem_p1, rem_nx, div_sub, quo_nx, quo_res, rem_res;
  logic [DATA_W:0]   div_shift;
  logic              div_ge;

  always_ff @(posedge clk) begin
    if (accept_run) begin
      is_div_p0  <= op[1];
      neg_rem_p0 <= s1_neg;
      div0_p0    <= (src2 == '0);
      src1_p0    <= src1;
      rem_p1     <= '0;
    end else if (state_q == S_RUN) begin
      rem_p1 <= rem_nx;
    end
  end

  // p1: one restoring-divide step; the 33-bit trial remainder always fits 32 bits after restore
  assign div_shift = {rem_p1, acc_p1[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_p0});
  assign div_sub   = div_shift[DATA_W-1:0] - opnd_p0;
  assign rem_nx    = div_ge ? div_sub : div_shift[DATA_W-1:0];
  assign quo_nx    = {acc_p1[DATA_W-2:0], div_ge};
  assign acc_nx    = is_div_p0 ? {acc_p1[2*DATA_W-1:DATA_W], quo_nx} : mul_nx;

  assign quo_res = div0_p0 ? {DATA_W{1'b1}} : cond_neg32(quo_nx, neg_res_p0);
  assign rem_res = div0_p0 ? src1_p0 : cond_neg32(rem_nx, neg_rem_p0);
  assign res_hi  = is_div_p0 ? rem_res : mul_res[2*DATA_W-1:DATA_W];
  assign res_lo  = is_div_p0 ? quo_res : mul_res[DATA_W-1:0];
`else
  assign acc_nx = mul_nx;
  assign res_hi = mul_res[2*DATA_W-1:DATA_W];
  assign res_lo = mul_res[DATA_W-1:0];
`endif

  // p2: architectural HI/LO; MT writes only land while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (last && !flush) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state_q == S_IDLE) begin
      if (hi_wen) hi <= wdata;
      if (lo_wen) lo <= wdata;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Directed bench for ex_muldiv_hilo; divide checks follow the MULDIV_DIV_EN build option.
module tb_ex_muldiv_hilo;
  logic        clk, resetn, start, hi_wen, lo_wen, flush;
  logic [1:0]  op;
  logic [31:0] src1, src2, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          tests, fails;

  ex_muldiv_hilo dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src1(src1), .src2(src2),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream stalls keep MT writes away from a busy unit; flag any stimulus that breaks that.
  always @(posedge clk) begin
    if (resetn && busy && (hi_wen || lo_wen)) begin
      fails++;
      $display("FAIL mt_while_busy: hi_wen=%0b lo_wen=%0b busy=%0b, required no write while busy", hi_wen, lo_wen, busy);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int done_at, output int busy_cycles);
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles = 0;
    done_at = -1;
    if (done) done_at = 0;
    else if (busy) busy_cycles++;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      @(posedge clk); #1;
      if (done) done_at = i;
      else if (busy) busy_cycles++;
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    hi_wen = h; lo_wen = l; wdata = d;
    @(posedge clk); #1;
    hi_wen = 1'b0; lo_wen = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b, required 0", done); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h, required 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h, required 00000000", lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy_after: got %0b, required 0", busy); end
  endtask

  task automatic test_mult_signed;
    int d, b;
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, d, b);
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %h, required ffffffff", hi); end
    tests++; if (lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_lo: got %h, required fffffffa", lo); end
    tests++; if (d !== 32) begin fails++; $display("FAIL mult_latency: done after %0d edges, required 32", d); end
    tests++; if (b !== 32) begin fails++; $display("FAIL mult_busy_cycles: got %0d, required 32", b); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse: got %0b, required 0", done); end
  endtask

  task automatic test_multu;
    int d, b;
    run_op(2'b01, 32'hFFFFFFFE, 32'd3, d, b);
    tests++; if (hi !== 32'h00000002) begin fails++; $display("FAIL multu_hi: got %h, required 00000002", hi); end
    tests++; if (lo !== 32'hFFFFFFFA) begin fails++; $display("FAIL multu_lo: got %h, required fffffffa", lo); end
    tests++; if (d !== 32) begin fails++; $display("FAIL multu_latency: got %0d, required 32", d); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_divide;
    int d, b;
    run_op(2'b11, 32'd100, 32'd7, d, b);
    tests++; if (lo !== 32'h0000000E) begin fails++; $display("FAIL divu_lo: got %h, required 0000000e", lo); end
    tests++; if (hi !== 32'h00000002) begin fails++; $display("FAIL divu_hi: got %h, required 00000002", hi); end
    tests++; if (d !== 32) begin fails++; $display("FAIL divu_latency: got %0d, required 32", d); end
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, d, b);
    tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo: got %h, required fffffffd", lo); end
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi: got %h, required ffffffff", hi); end
    run_op(2'b10, 32'h12345678, 32'h0, d, b);
    tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL div0_lo: got %h, required ffffffff", lo); end
    tests++; if (hi !== 32'h12345678) begin fails++; $display("FAIL div0_hi: got %h, required 12345678", hi); end
    tests++; if (d !== 32) begin fails++; $display("FAIL div0_latency: got %0d, required 32", d); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, d, b);
    tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo: got %h, required 80000000", lo); end
    tests++; if (hi !== 32'h00000000) begin fails++; $display("FAIL div_ovf_hi: got %h, required 00000000", hi); end
  endtask
`else
  task automatic test_divide;
    int d, b;
    mt_write(1'b1, 1'b1, 32'h5A5A5A5A);
    run_op(2'b10, 32'd100, 32'd7, d, b);
    tests++; if (d !== 0) begin fails++; $display("FAIL nodiv_latency: got %0d, required 0", d); end
    tests++; if (b !== 0) begin fails++; $display("FAIL nodiv_busy: got %0d busy cycles, required 0", b); end
    tests++; if (hi !== 32'h5A5A5A5A) begin fails++; $display("FAIL nodiv_hi: got %h, required 5a5a5a5a", hi); end
    tests++; if (lo !== 32'h5A5A5A5A) begin fails++; $display("FAIL nodiv_lo: got %h, required 5a5a5a5a", lo); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL nodiv_done_pulse: got %0b, required 0", done); end
    run_op(2'b11, 32'h12345678, 32'h0, d, b);
    tests++; if (d !== 0) begin fails++; $display("FAIL nodiv_divu_latency: got %0d, required 0", d); end
    tests++; if (lo !== 32'h5A5A5A5A) begin fails++; $display("FAIL nodiv_divu_lo: got %h, required 5a5a5a5a", lo); end
  endtask
`endif

  task automatic test_flush_mt;
    int seen;
    mt_write(1'b1, 1'b1, 32'h11111111);
    mt_write(1'b0, 1'b1, 32'h22222222);
    @(negedge clk);
    op = 2'b00; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %0b, required 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL flush_done: got %0b, required 0", done); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush_no_done: saw %0d done cycles, required 0", seen); end
    tests++; if (hi !== 32'h11111111) begin fails++; $display("FAIL flush_hi: got %h, required 11111111", hi); end
    tests++; if (lo !== 32'h22222222) begin fails++; $display("FAIL flush_lo: got %h, required 22222222", lo); end
    mt_write(1'b1, 1'b0, 32'hCAFEF00D);
    tests++; if (hi !== 32'hCAFEF00D) begin fails++; $display("FAIL mthi: got %h, required cafef00d", hi); end
    tests++; if (lo !== 32'h22222222) begin fails++; $display("FAIL mthi_lo_kept: got %h, required 22222222", lo); end
  endtask

  task automatic test_start_flush;
    @(negedge clk);
    op = 2'b01; src1 = 32'd9; src2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_flush_busy: got %0b, required 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL start_flush_done: got %0b, required 0", done); end
  endtask

  task automatic test_start_with_mt;
    int waited;
    @(negedge clk);
    op = 2'b01; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
    hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'h00001234;
    @(posedge clk); #1;
    start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    tests++; if (hi !== 32'h00001234) begin fails++; $display("FAIL start_mt_hi: got %h, required 00001234", hi); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_mt_busy: got %0b, required 1", busy); end
    waited = 0;
    while (!done && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    tests++; if (waited !== 32) begin fails++; $display("FAIL start_mt_latency: got %0d, required 32", waited); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL start_mt_res_hi: got %h, required 00000000", hi); end
    tests++; if (lo !== 32'd30) begin fails++; $display("FAIL start_mt_res_lo: got %h, required 0000001e", lo); end
  endtask

  task automatic test_back_to_back;
    int d, b;
    run_op(2'b01, 32'd7, 32'd6, d, b);
    tests++; if (lo !== 32'd42) begin fails++; $display("FAIL b2b_first_lo: got %h, required 0000002a", lo); end
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, d, b);
    tests++; if (d !== 32) begin fails++; $display("FAIL b2b_latency: got %0d, required 32", d); end
    tests++; if (b !== 32) begin fails++; $display("FAIL b2b_busy_cycles: got %0d, required 32", b); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL b2b_hi: got %h, required 00000000", hi); end
    tests++; if (lo !== 32'h1) begin fails++; $display("FAIL b2b_lo: got %h, required 00000001", lo); end
  endtask

  task automatic test_reset_midrun;
    mt_write(1'b1, 1'b1, 32'hAAAA5555);
    @(negedge clk);
    op = 2'b00; src1 = 32'd11; src2 = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrun_busy_before: got %0b, required 1", busy); end
    @(negedge clk); resetn = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_reset_busy: got %0b, required 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL midrun_reset_hi: got %h, required 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL midrun_reset_lo: got %h, required 00000000", lo); end
    @(negedge clk); resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests++; if (done !== 1'b0 || lo !== 32'h0) begin fails++; $display("FAIL midrun_no_resume: done=%0b lo=%h, required done=0 lo=00000000", done, lo); end
  endtask

  initial begin
    tests = 0; fails = 0;
    resetn = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0; flush = 1'b0;
    test_reset();
    test_mult_signed();
    test_multu();
    test_divide();
    test_flush_mt();
    test_start_flush();
    test_start_with_mt();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
